// File: rtl/score_history_pkg.sv
// Shared definitions for the score_history block: game-state encodings,
// default sizing and the update FSM state type.
package score_history_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RES  = 2'd3;

  localparam int W_DEF     = 10;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UPD  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } fsm_t;

endpackage

// File: rtl/score_history_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved in
// the start cycle itself, so the quotient is complete NW edges after start.
module seq_divider
  import score_history_pkg::*;
#(
  parameter int NW = 13,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int            CW   = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  logic [NW-1:0] work_q;
  logic [NW-1:0] src_work;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] src_rem;
  logic [DW-1:0] den_q;
  logic [DW-1:0] src_den;
  logic [DW-1:0] rem_d;
  logic [DW:0]   trial;
  logic          fits;
  logic [CW-1:0] step_q;
  logic          run_q;

  // NOTE: every signal gets a value before any branch, so no latch is inferred.
  always_comb begin
    src_work = start ? num : work_q;
    src_rem  = start ? '0 : rem_q;
    src_den  = start ? den : den_q;
    trial    = {src_rem, src_work[NW-1]};
    fits     = (trial >= {1'b0, src_den});
    // The remainder after a successful subtract is below den, so DW bits suffice.
    rem_d    = fits ? (trial[DW-1:0] - src_den) : trial[DW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      work_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || run_q) begin
        work_q <= {src_work[NW-2:0], fits};
        rem_q  <= rem_d;
      end
      if (start) begin
        den_q  <= den;
        step_q <= CW'(1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        step_q <= step_q + CW'(1);
        if (step_q == LAST) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign quotient = work_q;

endmodule

// File: rtl/score_history.sv
// Per-mode run statistics: all-time best and windowed floor average of wpm and
// acc, refreshed by a multi-cycle update whenever a run finishes.
module score_history
  import score_history_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [1:0]    state,
  input  logic [W-1:0]  wpm,
  input  logic [W-1:0]  acc,
  input  logic          clear,
  output logic [W-1:0]  wpm_best,
  output logic [W-1:0]  wpm_average,
  output logic [W-1:0]  acc_best,
  output logic [W-1:0]  acc_average,
  output logic [AW:0]   run_count,
  output logic          busy,
  output logic          dropped
);

  localparam int        SW   = W + AW;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [1:0]   state_q;
  fsm_t         fsm_q;
  fsm_t         fsm_d;

  logic         commit;
  logic         commit_take;
  logic         commit_to_slot;
  logic         slot_take;

  logic         cur_mode;
  logic [W-1:0] cur_wpm;
  logic [W-1:0] cur_acc;
  logic         slot_valid_q;
  logic         slot_mode;
  logic [W-1:0] slot_wpm;
  logic [W-1:0] slot_acc;

  logic [W-1:0]  wpm_buf   [2][DEPTH];
  logic [W-1:0]  acc_buf   [2][DEPTH];
  logic [SW-1:0] wpm_sum_q [2];
  logic [SW-1:0] acc_sum_q [2];
  logic [AW:0]   cnt_q     [2];
  logic [AW-1:0] wptr_q    [2];
  logic [W-1:0]  wpm_max_q [2];
  logic [W-1:0]  acc_max_q [2];
  logic [W-1:0]  wpm_avg_q [2];
  logic [W-1:0]  acc_avg_q [2];

  logic          evict;
  logic [SW-1:0] wpm_sum_d;
  logic [SW-1:0] acc_sum_d;
  logic [AW:0]   cnt_d;

  logic          div_start;
  logic          wpm_done;
  logic          acc_done;
  logic [SW-1:0] wpm_quot;
  logic [SW-1:0] acc_quot;

  // Only the 2->3 edge of the game state commits; a held result does not.
  assign commit         = (state_q == ST_RUN) && (state == ST_RES) && !clear;
  assign slot_take      = slot_valid_q && ((fsm_q == S_IDLE) || (fsm_q == S_DONE));
  assign commit_take    = commit && (fsm_q == S_IDLE) && !slot_valid_q;
  assign commit_to_slot = commit && !commit_take;
  assign busy           = (fsm_q != S_IDLE);
  assign div_start      = (fsm_q == S_UPD);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state;
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) fsm_q <= S_IDLE;
    else               fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: if (slot_valid_q || commit) fsm_d = S_UPD;
      S_UPD:  fsm_d = S_DIV;
      S_DIV:  if (wpm_done && acc_done) fsm_d = S_DONE;
      S_DONE: fsm_d = slot_valid_q ? S_UPD : S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Current run register and the 1-deep holding slot for commits during busy.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cur_mode     <= 1'b0;
      cur_wpm      <= '0;
      cur_acc      <= '0;
      slot_valid_q <= 1'b0;
      slot_mode    <= 1'b0;
      slot_wpm     <= '0;
      slot_acc     <= '0;
      dropped      <= 1'b0;
    end else begin
      if (slot_take) begin
        cur_mode <= slot_mode;
        cur_wpm  <= slot_wpm;
        cur_acc  <= slot_acc;
      end else if (commit_take) begin
        cur_mode <= mode;
        cur_wpm  <= wpm;
        cur_acc  <= acc;
      end
      if (commit_to_slot) begin
        if (!slot_valid_q || slot_take) begin
          slot_valid_q <= 1'b1;
          slot_mode    <= mode;
          slot_wpm     <= wpm;
          slot_acc     <= acc;
        end else begin
          dropped <= 1'b1;
        end
      end else if (slot_take) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

  // Next sums and count for the bank being updated; also the divider operands.
  always_comb begin
    evict     = (cnt_q[cur_mode] == FULL);
    wpm_sum_d = wpm_sum_q[cur_mode] + SW'(cur_wpm);
    acc_sum_d = acc_sum_q[cur_mode] + SW'(cur_acc);
    cnt_d     = cnt_q[cur_mode] + (AW + 1)'(1);
    if (evict) begin
      wpm_sum_d = wpm_sum_d - SW'(wpm_buf[cur_mode][wptr_q[cur_mode]]);
      acc_sum_d = acc_sum_d - SW'(acc_buf[cur_mode][wptr_q[cur_mode]]);
      cnt_d     = cnt_q[cur_mode];
    end
  end

  // NOTE: the history buffers take the synchronous reset like every other
  // register, so a wiped bank never averages stale entries.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < DEPTH; i++) begin
          wpm_buf[m][i] <= '0;
          acc_buf[m][i] <= '0;
        end
        wpm_sum_q[m] <= '0;
        acc_sum_q[m] <= '0;
        cnt_q[m]     <= '0;
        wptr_q[m]    <= '0;
        wpm_max_q[m] <= '0;
        acc_max_q[m] <= '0;
        wpm_avg_q[m] <= '0;
        acc_avg_q[m] <= '0;
      end
    end else begin
      if (fsm_q == S_UPD) begin
        wpm_buf[cur_mode][wptr_q[cur_mode]] <= cur_wpm;
        acc_buf[cur_mode][wptr_q[cur_mode]] <= cur_acc;
        wpm_sum_q[cur_mode] <= wpm_sum_d;
        acc_sum_q[cur_mode] <= acc_sum_d;
        cnt_q[cur_mode]     <= cnt_d;
        wptr_q[cur_mode]    <= wptr_q[cur_mode] + AW'(1);
        if (cur_wpm > wpm_max_q[cur_mode]) wpm_max_q[cur_mode] <= cur_wpm;
        if (cur_acc > acc_max_q[cur_mode]) acc_max_q[cur_mode] <= cur_acc;
      end
      if (fsm_q == S_DONE) begin
        // Sum never exceeds cnt * max value, so the upper quotient bits stay 0.
        wpm_avg_q[cur_mode] <= (|wpm_quot[SW-1:W]) ? {W{1'b1}} : wpm_quot[W-1:0];
        acc_avg_q[cur_mode] <= (|acc_quot[SW-1:W]) ? {W{1'b1}} : acc_quot[W-1:0];
      end
    end
  end

  seq_divider #(.NW(SW), .DW(AW + 1)) u_wpm_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (clear),
    .start    (div_start),
    .num      (wpm_sum_d),
    .den      (cnt_d),
    .done     (wpm_done),
    .quotient (wpm_quot)
  );

  seq_divider #(.NW(SW), .DW(AW + 1)) u_acc_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (clear),
    .start    (div_start),
    .num      (acc_sum_d),
    .den      (cnt_d),
    .done     (acc_done),
    .quotient (acc_quot)
  );

  // Registered view of the selected bank; an empty bank reads as all zero.
  always_ff @(posedge clk) begin
    if (!rst || clear || (cnt_q[mode] == '0)) begin
      wpm_best    <= '0;
      wpm_average <= '0;
      acc_best    <= '0;
      acc_average <= '0;
      run_count   <= '0;
    end else begin
      wpm_best    <= wpm_max_q[mode];
      wpm_average <= wpm_avg_q[mode];
      acc_best    <= acc_max_q[mode];
      acc_average <= acc_avg_q[mode];
      run_count   <= cnt_q[mode];
    end
  end

endmodule
